// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;
  localparam int MIN_DIVIDER = 8;
  localparam int MAX_DATA_W  = 9;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } rx_state_e;

  // data is sized for the widest legal character; narrower builds zero-extend
  typedef struct packed {
    logic                  brk;
    logic                  ferr;
    logic                  perr;
    logic [MAX_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit for full/empty.
module uart_rx_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         wr_en_i,
  input  logic [W-1:0] wdata_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rdata_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr_q, rptr_q;
  logic         push, pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  // a write into a full FIFO is accepted only when the head leaves in the same cycle
  assign push    = wr_en_i & (~full_o | rd_en_i);
  assign pop     = rd_en_i & ~empty_o;
  assign rdata_o = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: synchroniser, 3-tap majority bit sampling, per-frame config latch,
// error tagging and a show-ahead receive FIFO.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              rx_i,
  input  logic [DIV_W-1:0]  divider_i,
  input  logic [1:0]        parity_i,
  input  logic              stop2_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_perr_o,
  output logic              m_ferr_o,
  output logic              m_brk_o,
  output logic              overflow_o,
  input  logic              clr_ovf_i,
  output logic              busy_o
);
  logic              rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_e         state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d, div_in;
  parity_e           par_q, par_d;
  logic              stop2_q, stop2_d;
  logic [DATA_W-1:0] shr_q, shr_d;
  logic [3:0]        bit_q, bit_d;
  logic              perr_q, perr_d, pbit_q, pbit_d;
  logic [1:0]        smp_q, smp_d;
  logic              arm_q, arm_d;
  logic              wr_q, wr_d;
  rx_entry_t         ent_q, ent_d, head;
  logic              ovf_q, ovf_d;
  logic              bit_v, fifo_empty, fifo_full, pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    shr_d   = shr_q;
    bit_d   = bit_q;
    perr_d  = perr_q;
    pbit_d  = pbit_q;
    smp_d   = smp_q;
    arm_d   = arm_q;
    wr_d    = 1'b0;
    ent_d   = ent_q;
    bit_v   = maj3(smp_q[0], smp_q[1], rx_s2_q);
    div_in  = (divider_i < DIV_W'(MIN_DIVIDER)) ? DIV_W'(MIN_DIVIDER) : divider_i;

    if (state_q == IDLE) begin
      if (rx_s2_q) arm_d = 1'b1;
      if (arm_q && rx_prev_q && !rx_s2_q) begin
        div_d   = div_in;
        par_d   = (parity_i == 2'b01) ? PAR_EVEN :
                  (parity_i == 2'b10) ? PAR_ODD  : PAR_NONE;
        stop2_d = stop2_i;
        cnt_d   = div_in >> 1;
        perr_d  = 1'b0;
        pbit_d  = 1'b0;
        state_d = START;
      end
    end else begin
      if (cnt_q == DIV_W'(2)) smp_d[0] = rx_s2_q;
      if (cnt_q == DIV_W'(1)) smp_d[1] = rx_s2_q;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - DIV_W'(1);
      end else begin
        cnt_d = div_q - DIV_W'(1);
        case (state_q)
          START: begin
            bit_d   = '0;
            state_d = bit_v ? IDLE : DATA;
          end
          DATA: begin
            shr_d = {bit_v, shr_q[DATA_W-1:1]};
            bit_d = bit_q + 4'd1;
            if (bit_q == 4'(DATA_W - 1))
              state_d = (par_q != PAR_NONE) ? PARITY : STOP1;
          end
          PARITY: begin
            pbit_d  = bit_v;
            perr_d  = bit_v ^ (^shr_q) ^ (par_q == PAR_ODD);
            state_d = STOP1;
          end
          STOP1: begin
            if (!bit_v || !stop2_q) begin
              // a break is an all-zero character with every framing bit low
              wr_d    = 1'b1;
              ent_d   = '{brk:  !bit_v && (shr_q == '0) && !pbit_q,
                          ferr: !bit_v, perr: perr_q,
                          data: MAX_DATA_W'(shr_q)};
              arm_d   = bit_v;
              state_d = IDLE;
            end else begin
              state_d = STOP2;
            end
          end
          STOP2: begin
            wr_d    = 1'b1;
            ent_d   = '{brk: 1'b0, ferr: !bit_v, perr: perr_q,
                        data: MAX_DATA_W'(shr_q)};
            arm_d   = bit_v;
            state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_q     <= DIV_W'(MIN_DIVIDER);
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      shr_q     <= '0;
      bit_q     <= '0;
      perr_q    <= 1'b0;
      pbit_q    <= 1'b0;
      smp_q     <= '0;
      arm_q     <= 1'b1;
      wr_q      <= 1'b0;
      ent_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rx_s1_q   <= rx_i;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      par_q     <= par_d;
      stop2_q   <= stop2_d;
      shr_q     <= shr_d;
      bit_q     <= bit_d;
      perr_q    <= perr_d;
      pbit_q    <= pbit_d;
      smp_q     <= smp_d;
      arm_q     <= arm_d;
      wr_q      <= wr_d;
      ent_q     <= ent_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pop   = m_valid_o & m_ready_i;
  assign ovf_d = (ovf_q & ~clr_ovf_i) | (wr_q & fifo_full & ~pop);

  uart_rx_fifo #(
    .W     ($bits(rx_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .wr_en_i (wr_q),
    .wdata_i (ent_q),
    .rd_en_i (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // outputs are forced to zero while empty so stale RAM never leaks out
  assign m_valid_o  = ~fifo_empty;
  assign m_data_o   = m_valid_o ? DATA_W'(head.data) : '0;
  assign m_perr_o   = m_valid_o & head.perr;
  assign m_ferr_o   = m_valid_o & head.ferr;
  assign m_brk_o    = m_valid_o & head.brk;
  assign overflow_o = ovf_q;
  assign busy_o     = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames are driven bit-serially, expected entries
// are queued at send time and compared when the DUT pops them.
module tb_uart_rx_ctrl;
  localparam int DW  = 8;
  localparam int DIV = 16;

  logic          gclk = 1'b0;
  logic          grst_n;
  logic          rx, m_ready, clr_ovf, stop2;
  logic [1:0]    parity;
  logic [31:0]   divider;
  logic          m_valid, m_perr, m_ferr, m_brk, ovf, busy;
  logic [DW-1:0] m_data;

  int          errors = 0;
  int          checks = 0;
  logic [10:0] exp_q[$];
  logic [10:0] mon_exp;

  uart_rx_ctrl #(.DATA_W(DW), .FIFO_DEPTH(16), .DIV_W(32)) dut (
    .clk_i(gclk), .rst_n_i(grst_n), .rx_i(rx), .divider_i(divider),
    .parity_i(parity), .stop2_i(stop2), .m_valid_o(m_valid), .m_ready_i(m_ready),
    .m_data_o(m_data), .m_perr_o(m_perr), .m_ferr_o(m_ferr), .m_brk_o(m_brk),
    .overflow_o(ovf), .clr_ovf_i(clr_ovf), .busy_o(busy)
  );

  always #5 gclk = ~gclk;

  function automatic logic [10:0] mk(input logic b, input logic f, input logic p,
                                     input logic [7:0] d);
    return {b, f, p, d};
  endfunction

  // pops happen on the next rising edge, so each negedge with valid&ready is one entry
  always @(negedge gclk) begin
    if (grst_n && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got brk=%0d ferr=%0d perr=%0d data=%h, expected no entry",
                 m_brk, m_ferr, m_perr, m_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({m_brk, m_ferr, m_perr, m_data} !== mon_exp) begin
          errors++;
          $display("FAIL sb_entry: got {brk,ferr,perr,data}=%h, expected %h",
                   {m_brk, m_ferr, m_perr, m_data}, mon_exp);
        end
      end
    end
  end

  // Caller must be at a negedge. last_cyc = hold time of the final stop bit.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic s1, input logic use_s2, input logic s2,
                            input int glitch_bit, input int last_cyc);
    logic bits[13];
    int   n;
    n = 0;
    bits[n++] = 1'b0;
    for (int i = 0; i < DW; i++) bits[n++] = d[i];
    if (pen) bits[n++] = pbit;
    bits[n++] = s1;
    if (use_s2) bits[n++] = s2;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      if (i == glitch_bit) begin
        repeat (8) @(negedge gclk);
        rx = ~bits[i];
        @(negedge gclk);
        rx = bits[i];
        repeat (DIV - 9) @(negedge gclk);
      end else begin
        repeat ((i == n - 1) ? last_cyc : DIV) @(negedge gclk);
      end
    end
    if (last_cyc > 0) rx = 1'b1;
  endtask

  task automatic test_reset();
    grst_n = 1'b0; rx = 1'b1; m_ready = 1'b0; clr_ovf = 1'b0;
    stop2 = 1'b0; parity = 2'b00; divider = DIV;
    repeat (3) @(negedge gclk);
    checks += 7;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", m_valid); end
    if (m_data  !== '0)   begin errors++; $display("FAIL rst_data: got %h want 00", m_data); end
    if (m_perr  !== 1'b0) begin errors++; $display("FAIL rst_perr: got %b want 0", m_perr); end
    if (m_ferr  !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b want 0", m_ferr); end
    if (m_brk   !== 1'b0) begin errors++; $display("FAIL rst_brk: got %b want 0", m_brk); end
    if (ovf     !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    if (busy    !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    grst_n = 1'b1;
    repeat (5) @(negedge gclk);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_rst: got busy=%b valid=%b want 0 0", busy, m_valid);
    end
  endtask

  task automatic test_basic();
    m_ready = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 8'hA5));
    send_frame(8'hA5, 0, 0, 1, 0, 1, -1, 0);
    // stop-bit decision is 155 edges after the start edge; valid follows two edges later
    repeat (12) @(negedge gclk);
    checks++;
    if (m_valid !== 1'b0) begin errors++; $display("FAIL valid_early: got %b want 0", m_valid); end
    @(negedge gclk);
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL valid_rise: got %b want 1", m_valid); end
    repeat (20) @(negedge gclk);
    checks++;
    if ({m_valid, m_brk, m_ferr, m_perr, m_data} !== {1'b1, 3'b000, 8'hA5}) begin
      errors++;
      $display("FAIL head_stable: got valid=%b flags=%b%b%b data=%h want 1 000 a5",
               m_valid, m_brk, m_ferr, m_perr, m_data);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge gclk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_parity();
    logic [7:0] d[4]  = '{8'h03, 8'h07, 8'h07, 8'h00};
    logic       pb[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic       od[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      parity = od[k] ? 2'b10 : 2'b01;
      exp_q.push_back(mk(0, 0, pb[k] ^ (^d[k]) ^ od[k], d[k]));
      send_frame(d[k], 1, pb[k], 1, 0, 1, -1, DIV);
    end
    parity = 2'b00;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge gclk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL parity_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_false_start_glitch();
    m_ready = 1'b1;
    rx = 1'b0;
    repeat (3) @(negedge gclk);
    rx = 1'b1;
    repeat (2) @(negedge gclk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL fs_busy: got %b want 1", busy); end
    repeat (30) @(negedge gclk);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL false_start: got busy=%b valid=%b want 0 0", busy, m_valid);
    end
    exp_q.push_back(mk(0, 0, 0, 8'hA5));
    send_frame(8'hA5, 0, 0, 1, 0, 1, 2, DIV);
    exp_q.push_back(mk(0, 0, 0, 8'h5B));
    send_frame(8'h5B, 0, 0, 1, 0, 1, 1, DIV);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge gclk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL glitch_drain: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_break();
    m_ready = 1'b1;
    exp_q.push_back(mk(1, 1, 0, 8'h00));
    rx = 1'b0;
    repeat (40 * DIV) @(negedge gclk);
    rx = 1'b1;
    repeat (2 * DIV) @(negedge gclk);
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL break_once: left=%0d busy=%b want 0 0", exp_q.size(), busy);
    end
    exp_q.push_back(mk(0, 0, 0, 8'h55));
    send_frame(8'h55, 0, 0, 1, 0, 1, -1, DIV);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge gclk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL after_break: %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(mk(0, 0, 0, 8'(i)));
      send_frame(8'(i), 0, 0, 1, 0, 1, -1, DIV);
      if (i == 15) begin
        checks++;
        if (ovf !== 1'b0 || m_valid !== 1'b1) begin
          errors++; $display("FAIL full_no_ovf: got ovf=%b valid=%b want 0 1", ovf, m_valid);
        end
      end
    end
    checks += 2;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", ovf); end
    if (m_data !== 8'h00) begin errors++; $display("FAIL ovf_head: got %h want 00", m_data); end
    clr_ovf = 1'b1;
    @(negedge gclk);
    clr_ovf = 1'b0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", ovf); end
    m_ready = 1'b1;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || m_valid); i++) @(negedge gclk);
    checks++;
    if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drain: left=%0d valid=%b want 0 0", exp_q.size(), m_valid);
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    exp_q.push_back(mk(0, 0, 0, 8'h11));
    send_frame(8'h11, 0, 0, 1, 0, 1, -1, DIV);
    rx = 1'b0; repeat (DIV) @(negedge gclk);
    rx = 1'b1; repeat (DIV) @(negedge gclk);
    rx = 1'b0; repeat (DIV / 2) @(negedge gclk);
    checks++;
    if (busy !== 1'b1 || m_valid !== 1'b1) begin
      errors++; $display("FAIL pre_rst: got busy=%b valid=%b want 1 1", busy, m_valid);
    end
    grst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({m_valid, m_data, m_perr, m_ferr, m_brk, ovf, busy} !== '0) begin
      errors++;
      $display("FAIL mid_rst_outputs: got valid=%b data=%h p=%b f=%b b=%b ovf=%b busy=%b want all 0",
               m_valid, m_data, m_perr, m_ferr, m_brk, ovf, busy);
    end
    @(negedge gclk);
    rx = 1'b1;
    repeat (3) @(negedge gclk);
    grst_n = 1'b1;
    repeat (5) @(negedge gclk);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_rst: got valid=%b busy=%b want 0 0", m_valid, busy);
    end
    stop2 = 1'b1;
    m_ready = 1'b1;
    exp_q.push_back(mk(0, 1, 0, 8'h3C));
    send_frame(8'h3C, 0, 0, 1, 1, 0, -1, DIV);
    stop2 = 1'b0;
    repeat (DIV) @(negedge gclk);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge gclk);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL stop2_drain: %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    @(negedge gclk);
    test_reset();
    test_basic();
    test_parity();
    test_false_start_glitch();
    test_break();
    test_overflow();
    test_reset_mid();
    repeat (5) @(negedge gclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Parametrised UART receiver with runtime-programmable baud divider, parity mode and stop-bit count, 3-tap majority sampling, per-character error tagging and an internal receive FIFO. It replaces the fixed 8N1 receive path in the debug-bridge front end. It sits between the board RX pin and the byte-level protocol decoder, which consumes characters over a valid/ready stream.

## Interface
Parameters:
- DATA_W, 8, character width in bits, legal 5..9
- FIFO_DEPTH, 16, receive FIFO entries, power of two, at least 2
- DIV_W, 32, width of the divider input

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous, active-low reset
- rx_i  in  1  raw serial input, asynchronous to clk_i, idle high
- divider_i  in  DIV_W  clk_i cycles per bit, at least 8
- parity_i  in  2  00 none, 01 even, 10 odd, 11 treated as none
- stop2_i  in  1  1 = two stop bits expected
- m_valid_o  out  1  FIFO head valid
- m_ready_i  in  1  consumer accepts head
- m_data_o  out  DATA_W  received character, LSB first on the wire
- m_perr_o  out  1  head character had a parity error
- m_ferr_o  out  1  head character had a framing error (stop bit low)
- m_brk_o  out  1  head is a break (data all-zero, parity bit low if enabled, stop bit low)
- overflow_o  out  1  sticky: a character was dropped because the FIFO was full
- clr_ovf_i  in  1  clears overflow_o
- busy_o  out  1  frame reception in progress (state not IDLE)

## Operation
- rx_i passes through a 2-flop synchroniser (reset value 1). All decisions use the synchronised value.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: a falling edge on the synchronised rx latches divider_i, parity_i and stop2_i for the whole frame. It loads the bit counter with divider/2 and moves to START. Changes to the config inputs mid-frame have no effect until the next frame.
- Sample point: when the bit counter reaches centre-1, centre and centre+1, the three samples are taken. The bit value is the majority of the three. The counter then reloads with the divider.
- START: a majority value of 1 is a false start; return to IDLE and write nothing. A majority of 0 moves to DATA.
- DATA: shift DATA_W bits in, LSB first. Go to PARITY if parity is enabled, else to STOP1.
- PARITY: perr = received bit XOR expected bit. For even parity, the expected bit is the XOR of the data bits; for odd parity, it is the inverse of that.
- STOP1: ferr = bit is 0. With stop2 set and ferr clear, go to STOP2; otherwise write the entry and go to IDLE.
- STOP2: ferr is also set if this bit is 0; write the entry and go to IDLE.
- After a framing error, IDLE re-arms only once the synchronised rx is seen high. A held-low line therefore yields exactly one break entry.
- FIFO entry is {brk, ferr, perr, data}. The head is presented show-ahead on the m_* outputs.
- A write while the FIFO is full drops the new entry and sets overflow_o. A write and a pop in the same cycle while full both succeed.
- clr_ovf_i and an overflow event in the same cycle: overflow_o stays 1.

## Timing
- Reset values: m_valid_o 0, m_data_o 0, m_perr_o 0, m_ferr_o 0, m_brk_o 0, overflow_o 0, busy_o 0. FSM resets to IDLE and the FIFO resets to empty.
- Asynchronous reset mid-frame discards the partial character and any FIFO contents.
- Input latency: 2 cycles from rx_i to the synchronised value.
- m_valid_o rises 2 clk_i cycles after the final stop-bit sample cycle.
- A pop occurs on a rising edge with m_valid_o and m_ready_i both high. The next entry is visible in the following cycle.
- m_data_o and the flags are stable while m_valid_o is high and m_ready_i is low.
- Frame length is (1 + DATA_W + parity + 1 + stop2) × divider cycles.

## Structure
- Package uart_rx_pkg holds:
  - the parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD)
  - the rx_state_e FSM enum
  - the rx_entry_t packed struct {brk, ferr, perr, data}
  - the MIN_DIVIDER = 8 constant
- One sub-module, uart_rx_fifo: synchronous show-ahead FIFO parameterised on width and depth, with pointer wrap and an extra-bit full/empty scheme.

## Test plan
- divider 16, 8N1, send 0xA5: one entry with data 0xA5, perr 0, ferr 0, brk 0. m_valid_o is high 2 cycles after the stop-bit sample.
- parity 01 (even), 8E1, send 0x03 with parity bit 1: data 0x03, perr 1. Then send 0x07 with parity bit 1: perr 0.
- Pulse rx low for 3 cycles only (divider 16): no entry and busy_o returns to 0. A single-cycle glitch inside a data bit is voted out and the data is correct.
- Hold rx low for 40 bit times, then release: exactly one entry with data 0, ferr 1, brk 1. The next frame 0x55 is received cleanly.
- FIFO_DEPTH 16, send 17 characters 0x00..0x10 with m_ready_i low: 16 entries 0x00..0x0F are kept, 0x10 is dropped and overflow_o = 1. clr_ovf_i clears it.
- Assert rst_n_i low in the middle of the DATA state, then release: all outputs are at their reset values, and the following frame 0x3C (stop2 set, second stop bit low) gives ferr 1.
